tb_schedule_ctrl: RTL and testbench

//   Sequencer for the ping-pong transpose buffer between the memory fetch path and the

---
 rtl/tb_schedule_ctrl.sv | 110 +++++++++++
 tb/tb_tb_schedule_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tb_schedule_ctrl.sv
// Ping-pong transpose buffer sequencer. Steers incoming rows into the write
// bank, walks columns out of the read bank, and swaps banks per tile.
module tb_schedule_ctrl #(
   parameter int  NUM_ROWS = 4,
   parameter int  NUM_COLS = 4,
   localparam int RW       = $clog2(NUM_ROWS),
   localparam int CW       = $clog2(NUM_COLS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          mem_valid,
   output logic          mem_ready,
   output logic          wr_en,
   output logic          wr_bank,
   output logic [RW-1:0] wr_row,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          rd_bank,
   output logic [CW-1:0] rd_col,
   output logic          tile_done,
   output logic [1:0]    bank_full
);

   logic          wb_q, wb_d;
   logic          rb_q, rb_d;
   logic [RW-1:0] row_cnt_q, row_cnt_d;
   logic [CW-1:0] col_cnt_q, col_cnt_d;
   logic [1:0]    full_q, full_d;
   logic          tile_done_q, tile_done_d;
   logic          rd_en;
   logic          last_row, last_col;

   // Handshakes depend only on registered state, so there is no path from
   // mem_valid to out_valid or from out_ready to mem_ready. A flush cycle
   // suppresses both handshakes so nothing is written or consumed.
   assign mem_ready = ~full_q[wb_q];
   assign wr_en     = mem_valid & mem_ready & ~flush;
   assign wr_bank   = wb_q;
   assign wr_row    = row_cnt_q;
   assign out_valid = full_q[rb_q];
   assign rd_en     = out_valid & out_ready & ~flush;
   assign rd_bank   = rb_q;
   assign rd_col    = col_cnt_q;
   assign tile_done = tile_done_q;
   assign bank_full = full_q;

   // Explicit terminal compares so non-power-of-2 tile sizes wrap correctly.
   assign last_row = (row_cnt_q == RW'(NUM_ROWS - 1));
   assign last_col = (col_cnt_q == CW'(NUM_COLS - 1));

   // Next-state: write and read sides touch only their own bank's full bit.
   // A write needs full[wb]=0 and a read needs full[rb]=1, so the two sides
   // never target the same bit in one cycle.
   always_comb begin
      wb_d        = wb_q;
      rb_d        = rb_q;
      row_cnt_d   = row_cnt_q;
      col_cnt_d   = col_cnt_q;
      full_d      = full_q;
      tile_done_d = 1'b0;
      if (flush) begin
         wb_d      = 1'b0;
         rb_d      = 1'b0;
         row_cnt_d = '0;
         col_cnt_d = '0;
         full_d    = 2'b00;
      end else begin
         if (wr_en) begin
            if (last_row) begin
               full_d[wb_q] = 1'b1;
               wb_d         = ~wb_q;
               row_cnt_d    = '0;
            end else begin
               row_cnt_d = row_cnt_q + RW'(1);
            end
         end
         if (rd_en) begin
            if (last_col) begin
               full_d[rb_q] = 1'b0;
               rb_d         = ~rb_q;
               col_cnt_d    = '0;
               tile_done_d  = 1'b1;
            end else begin
               col_cnt_d = col_cnt_q + CW'(1);
            end
         end
      end
   end

   // State registers; reset discards any partial tile.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_q        <= 1'b0;
         rb_q        <= 1'b0;
         row_cnt_q   <= '0;
         col_cnt_q   <= '0;
         full_q      <= 2'b00;
         tile_done_q <= 1'b0;
      end else begin
         wb_q        <= wb_d;
         rb_q        <= rb_d;
         row_cnt_q   <= row_cnt_d;
         col_cnt_q   <= col_cnt_d;
         full_q      <= full_d;
         tile_done_q <= tile_done_d;
      end
   end

endmodule

// File: tb/tb_tb_schedule_ctrl.sv
// Directed bench for the transpose buffer sequencer: a 4x4 instance (a) and a
// 3x5 instance (b) share stimulus; b is checked after a common reset.
module tb_tb_schedule_ctrl;

   logic       clk = 1'b0;
   logic       rst, flush, mem_valid, out_ready;

   logic       a_mem_ready, a_wr_en, a_wr_bank, a_out_valid, a_rd_bank, a_tile_done;
   logic [1:0] a_wr_row, a_rd_col, a_bank_full;

   logic       b_mem_ready, b_wr_en, b_wr_bank, b_out_valid, b_rd_bank, b_tile_done;
   logic [1:0] b_wr_row, b_bank_full;
   logic [2:0] b_rd_col;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tb_schedule_ctrl #(.NUM_ROWS(4), .NUM_COLS(4)) u_a (
      .clk(clk), .rst(rst), .flush(flush), .mem_valid(mem_valid),
      .mem_ready(a_mem_ready), .wr_en(a_wr_en), .wr_bank(a_wr_bank), .wr_row(a_wr_row),
      .out_valid(a_out_valid), .out_ready(out_ready), .rd_bank(a_rd_bank), .rd_col(a_rd_col),
      .tile_done(a_tile_done), .bank_full(a_bank_full)
   );

   tb_schedule_ctrl #(.NUM_ROWS(3), .NUM_COLS(5)) u_b (
      .clk(clk), .rst(rst), .flush(flush), .mem_valid(mem_valid),
      .mem_ready(b_mem_ready), .wr_en(b_wr_en), .wr_bank(b_wr_bank), .wr_row(b_wr_row),
      .out_valid(b_out_valid), .out_ready(out_ready), .rd_bank(b_rd_bank), .rd_col(b_rd_col),
      .tile_done(b_tile_done), .bank_full(b_bank_full)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; mem_valid = 1'b0; out_ready = 1'b0;

      // reset state
      #2;
      chk("rst_mem_ready", a_mem_ready, 1);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_bank_full", a_bank_full, 0);
      chk("rst_wr_row", a_wr_row, 0);
      chk("rst_wr_en", a_wr_en, 0);
      chk("rst_tile_done", a_tile_done, 0);
      chk("rst_rd_col", a_rd_col, 0);
      cyc(); cyc();
      rst = 1'b0;

      // fill bank 0
      mem_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("fill_wr_en", a_wr_en, 1);
         chk("fill_wr_bank", a_wr_bank, 0);
         chk("fill_wr_row", a_wr_row, k);
         chk("fill_out_valid", a_out_valid, 0);
         cyc();
      end
      #1;
      chk("fill_bank_full", a_bank_full, 1);
      chk("fill_out_valid_after", a_out_valid, 1);
      chk("fill_wr_bank_after", a_wr_bank, 1);
      chk("fill_wr_row_after", a_wr_row, 0);

      // bank 1 fills, then producer stalls
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("fill1_wr_en", a_wr_en, 1);
         chk("fill1_wr_bank", a_wr_bank, 1);
         chk("fill1_wr_row", a_wr_row, k);
         cyc();
      end
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("stall_mem_ready", a_mem_ready, 0);
         chk("stall_wr_en", a_wr_en, 0);
         chk("stall_wr_row", a_wr_row, 0);
         chk("stall_bank_full", a_bank_full, 3);
         cyc();
      end

      // drain bank 0
      mem_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("drain_out_valid", a_out_valid, 1);
         chk("drain_rd_bank", a_rd_bank, 0);
         chk("drain_rd_col", a_rd_col, c);
         chk("drain_mem_ready", a_mem_ready, 0);
         chk("drain_tile_done", a_tile_done, 0);
         cyc();
      end
      #1;
      chk("drain_tile_done_pulse", a_tile_done, 1);
      chk("drain_mem_ready_after", a_mem_ready, 1);
      chk("drain_bank_full", a_bank_full, 2);
      chk("drain_rd_bank_after", a_rd_bank, 1);
      chk("drain_rd_col_after", a_rd_col, 0);
      out_ready = 1'b0;
      cyc();
      #1;
      chk("drain_tile_done_clear", a_tile_done, 0);
      chk("drain_bank_full_hold", a_bank_full, 2);

      // streaming: bank 1 is being read while bank 0 is written
      mem_valid = 1'b1; out_ready = 1'b1;
      for (int t = 0; t < 40; t++) begin
         #1;
         chk("str_wr_en", a_wr_en, 1);
         chk("str_out_valid", a_out_valid, 1);
         chk("str_wr_bank", a_wr_bank, (t / 4) % 2);
         chk("str_wr_row", a_wr_row, t % 4);
         chk("str_rd_bank", a_rd_bank, 1 - (t / 4) % 2);
         chk("str_rd_col", a_rd_col, t % 4);
         chk("str_tile_done", a_tile_done, (t > 0 && t % 4 == 0) ? 1 : 0);
         chk("str_bank_full", a_bank_full, 1 << (1 - (t / 4) % 2));
         cyc();
      end

      // flush with both handshakes requested
      flush = 1'b1;
      #1;
      chk("flush_wr_en", a_wr_en, 0);
      cyc();
      flush = 1'b0; mem_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("flush_bank_full", a_bank_full, 0);
      chk("flush_wr_row", a_wr_row, 0);
      chk("flush_wr_bank", a_wr_bank, 0);
      chk("flush_out_valid", a_out_valid, 0);
      chk("flush_tile_done", a_tile_done, 0);
      chk("flush_rd_bank", a_rd_bank, 0);

      // flush mid-tile after two rows
      mem_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("pre_flush_wr_row", a_wr_row, k);
         cyc();
      end
      flush = 1'b1;
      #1;
      chk("midflush_wr_en", a_wr_en, 0);
      chk("midflush_wr_row", a_wr_row, 2);
      cyc();
      flush = 1'b0;
      #1;
      chk("postflush_wr_row", a_wr_row, 0);
      chk("postflush_wr_bank", a_wr_bank, 0);
      chk("postflush_bank_full", a_bank_full, 0);
      chk("postflush_wr_en", a_wr_en, 1);

      // async reset mid-cycle with a full bank and partial tile
      for (int k = 0; k < 5; k++) cyc();
      #1;
      chk("prerst_bank_full", a_bank_full, 1);
      chk("prerst_wr_row", a_wr_row, 1);
      chk("prerst_wr_bank", a_wr_bank, 1);
      mem_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_bank_full", a_bank_full, 0);
      chk("arst_wr_row", a_wr_row, 0);
      chk("arst_wr_bank", a_wr_bank, 0);
      chk("arst_mem_ready", a_mem_ready, 1);
      chk("arst_out_valid", a_out_valid, 0);
      chk("arst_b_mem_ready", b_mem_ready, 1);
      #1;
      rst = 1'b0;
      cyc();

      // 3x5 instance: flush mid-tile, then wrap on both counters
      mem_valid = 1'b1; out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("b_wr_row", b_wr_row, k);
         chk("b_wr_bank", b_wr_bank, 0);
         cyc();
      end
      flush = 1'b1;
      #1;
      chk("b_flush_wr_en", b_wr_en, 0);
      cyc();
      flush = 1'b0;
      #1;
      chk("b_postflush_wr_row", b_wr_row, 0);
      chk("b_postflush_bank_full", b_bank_full, 0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("b_fill_wr_en", b_wr_en, 1);
         chk("b_fill_wr_row", b_wr_row, k);
         cyc();
      end
      #1;
      chk("b_fill_bank_full", b_bank_full, 1);
      chk("b_fill_wr_bank", b_wr_bank, 1);
      chk("b_fill_wr_row_wrap", b_wr_row, 0);
      chk("b_fill_out_valid", b_out_valid, 1);
      mem_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("b_drain_out_valid", b_out_valid, 1);
         chk("b_drain_rd_bank", b_rd_bank, 0);
         chk("b_drain_rd_col", b_rd_col, c);
         chk("b_drain_tile_done", b_tile_done, 0);
         cyc();
      end
      #1;
      chk("b_tile_done_pulse", b_tile_done, 1);
      chk("b_drain_bank_full", b_bank_full, 0);
      chk("b_drain_rd_bank_after", b_rd_bank, 1);
      chk("b_drain_rd_col_wrap", b_rd_col, 0);
      chk("b_drain_out_valid_after", b_out_valid, 0);
      out_ready = 1'b0;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
